// File: rtl/maxnet_if.sv
// ============================================================================
// maxnet_if : control/status bundle between maxnet_controller and datapath
// Rev 1.0
// ============================================================================
`default_nettype none

interface maxnet_if;
    logic        start;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] a3;
    logic        sel_init;
    logic        ld_act;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic        no_winner;
    logic        timeout;
    logic [7:0]  iter_count;

    // master = sequencing controller, slave = activation datapath
    modport master (
        input  start, a0, a1, a2, a3,
        output sel_init, ld_act, busy, done, winner, no_winner, timeout, iter_count
    );

    modport slave (
        output start, a0, a1, a2, a3,
        input  sel_init, ld_act, busy, done, winner, no_winner, timeout, iter_count
    );
endinterface

`default_nettype wire

// File: rtl/maxnet_controller.sv
// ============================================================================
// maxnet_controller : sequences Maxnet activation loads and detects the winner
// Rev 1.0
// ============================================================================
`default_nettype none

module maxnet_controller #(
    parameter int PE_LATENCY = 3,
    parameter int MAX_ITER   = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    maxnet_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_CHECK  = 3'd2,
        S_WAIT   = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] C_LAT      = 4'(PE_LATENCY);
    localparam logic [7:0] C_MAX_ITER = 8'(MAX_ITER);

    state_t      state_q;
    logic [3:0]  wait_q;
    logic        sel_init_q;
    logic        ld_act_q;
    logic        busy_q;
    logic        done_q;
    logic [1:0]  winner_q;
    logic        no_winner_q;
    logic        timeout_q;
    logic [7:0]  iter_q;

    logic [31:0] act [4];
    logic [3:0]  pos_vec;
    logic [2:0]  pos_cnt;
    logic [1:0]  pos_idx;

    assign act[0] = bus.a0;
    assign act[1] = bus.a1;
    assign act[2] = bus.a2;
    assign act[3] = bus.a3;

    // -0.0 and zero are not positive: sign clear and magnitude non-zero
    always_comb begin
        pos_vec = '0;
        pos_cnt = '0;
        pos_idx = '0;
        for (int i = 0; i < 4; i++) begin
            pos_vec[i] = ~act[i][31] & (|act[i][30:0]);
            if (pos_vec[i]) begin
                pos_cnt = pos_cnt + 3'd1;
                pos_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            sel_init_q  <= 1'b0;
            ld_act_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            winner_q    <= '0;
            no_winner_q <= 1'b0;
            timeout_q   <= 1'b0;
            iter_q      <= '0;
        end else begin
            sel_init_q <= 1'b0;
            ld_act_q   <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q    <= S_INIT;
                        sel_init_q <= 1'b1;
                        ld_act_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_INIT: begin
                    iter_q      <= '0;
                    winner_q    <= '0;
                    no_winner_q <= 1'b0;
                    timeout_q   <= 1'b0;
                    state_q     <= S_CHECK;
                end
                S_CHECK: begin
                    if (pos_cnt == 3'd1) begin
                        winner_q <= pos_idx;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (pos_cnt == 3'd0) begin
                        no_winner_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (iter_q == C_MAX_ITER) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        wait_q  <= C_LAT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_q <= wait_q - 4'd1;
                    if (wait_q <= 4'd1) begin
                        ld_act_q <= 1'b1;
                        state_q  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    iter_q  <= iter_q + 8'd1;
                    state_q <= S_CHECK;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sel_init   = sel_init_q;
    assign bus.ld_act     = ld_act_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.winner     = winner_q;
    assign bus.no_winner  = no_winner_q;
    assign bus.timeout    = timeout_q;
    assign bus.iter_count = iter_q;

endmodule

`default_nettype wire
